// File: rtl/button_repeat_ctrl.sv
// Push-button front end: synchronizes, arbitrates and emits press / auto-repeat pulses.
// Optional DEBOUNCE_EN macro inserts a per-bit stability filter after the synchronizer.
module button_repeat_ctrl #(
   parameter int N         = 11,
   parameter int NB        = 5,
   parameter int DB_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NB-1:0] btn_in,
   output logic [NB-1:0] btn_pulse,
   output logic [NB-1:0] btn_held,
   output logic          repeating
);

   localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int CNT_W = N - 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((2 ** (N - 1)) - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((2 ** (N - 2)) - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   if (N < 3 || NB < 1 || DB_CYCLES < 1) begin : g_bad_params
      $error("button_repeat_ctrl: illegal parameters (need N >= 3, NB >= 1, DB_CYCLES >= 1)");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   function automatic logic [SEL_W-1:0] lowest_idx(input logic [NB-1:0] v);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (v[i]) r = SEL_W'(i);
      end
      return r;
   endfunction

   function automatic logic [NB-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NB-1:0] r;
      r = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

   // Stage p0/p1: two-flop synchronizer on the asynchronous button levels
   logic [NB-1:0] sync_p0;
   logic [NB-1:0] sync_p1;
   logic [NB-1:0] s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= btn_in;
         sync_p1 <= sync_p0;
      end
   end

`ifdef DEBOUNCE_EN
   // Stage p2: a bit follows the synchronizer only after DB_CYCLES stable cycles
   localparam int DB_W = $clog2(DB_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

   logic [NB-1:0] filt_p2;

   for (genvar g = 0; g < NB; g++) begin : g_db
      logic [DB_W-1:0] db_cnt;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            filt_p2[g] <= 1'b0;
            db_cnt     <= '0;
         end else if (sync_p1[g] != filt_p2[g]) begin
            if (db_cnt == DB_LAST) begin
               filt_p2[g] <= sync_p1[g];
               db_cnt     <= '0;
            end else begin
               db_cnt <= db_cnt + DB_ONE;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign s = filt_p2;
`else
   assign s = sync_p1;
`endif

   // Control: grant/hold/repeat sequencer with registered outputs
   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] sel_n;
   logic [NB-1:0]    pulse_n;
   logic [NB-1:0]    held_n;
   logic             rep_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         sel       <= '0;
         btn_pulse <= '0;
         btn_held  <= '0;
         repeating <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         sel       <= sel_n;
         btn_pulse <= pulse_n;
         btn_held  <= held_n;
         repeating <= rep_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sel_n   = sel;
      pulse_n = '0;
      case (state)
         ST_IDLE: begin
            if (|s) begin
               sel_n   = lowest_idx(s);
               pulse_n = onehot(sel_n);
               cnt_n   = '0;
               state_n = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A release seen on the terminal count wins over the pulse
            if (!s[sel]) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else if (cnt == HOLD_LAST) begin
               pulse_n = onehot(sel);
               cnt_n   = '0;
               state_n = ST_REPEAT;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         ST_REPEAT: begin
            if (!s[sel]) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else if (cnt == REP_LAST) begin
               pulse_n = onehot(sel);
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            cnt_n   = '0;
            state_n = ST_IDLE;
         end
      endcase
      held_n = (state_n != ST_IDLE) ? onehot(sel_n) : '0;
      rep_n  = (state_n == ST_REPEAT);
   end

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Randomized bench for button_repeat_ctrl against a press-age reference model.
module tb_button_repeat_ctrl;

   localparam int N    = 4;
   localparam int NB   = 3;
   localparam int DB   = 4;
   localparam int HOLD = 2 ** (N - 1);
   localparam int REP  = 2 ** (N - 2);

   logic          clk = 1'b0;
   logic          reset;
   logic [NB-1:0] btn_in;
   logic [NB-1:0] btn_pulse;
   logic [NB-1:0] btn_held;
   logic          repeating;

   int checks   = 0;
   int failures = 0;

   // Reference: the button lands in the FSM two edges after sampling; the
   // expected outputs follow from how long the granted button has been held.
   logic [NB-1:0] m_q[$];
   int            m_sel;
   int            m_age;
   logic [NB-1:0] e_pulse;
   logic [NB-1:0] e_held;
   logic          e_rep;

   button_repeat_ctrl #(.N(N), .NB(NB), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (btn_in),
      .btn_pulse (btn_pulse),
      .btn_held  (btn_held),
      .repeating (repeating)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [NB-1:0] v);
      for (int i = 0; i < NB; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_q     = {};
      m_q.push_back('0);
      m_q.push_back('0);
      m_sel   = -1;
      m_age   = 0;
      e_pulse = '0;
      e_held  = '0;
      e_rep   = 1'b0;
   endtask

   task automatic model_step();
      logic [NB-1:0] s;
      if (reset) begin
         model_reset();
         return;
      end
      s = m_q.pop_front();
      m_q.push_back(btn_in);
      e_pulse = '0;
      if (m_sel < 0) begin
         if (s != '0) begin
            m_sel   = lowest(s);
            m_age   = 0;
            e_pulse = NB'(1) << m_sel;
         end
      end else if (!s[m_sel]) begin
         m_sel = -1;
      end else begin
         m_age++;
         if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
            e_pulse = NB'(1) << m_sel;
      end
      e_held = (m_sel >= 0) ? NB'(1) << m_sel : '0;
      e_rep  = (m_sel >= 0) && (m_age >= HOLD);
   endtask

   task automatic cycle(input logic [NB-1:0] b);
      btn_in = b;
      model_step();
      @(negedge clk);
      check("pulse", 32'(btn_pulse), 32'(e_pulse));
      check("held", 32'(btn_held), 32'(e_held));
      check("repeating", 32'(repeating), 32'(e_rep));
      check("pulse_onehot", 32'($countones(btn_pulse) <= 1), 32'(1));
   endtask

   task automatic segment(input logic [NB-1:0] b, input int len);
      for (int i = 0; i < len; i++) cycle(b);
   endtask

   initial begin
      model_reset();
      reset  = 1'b1;
      btn_in = '1;
      segment(3'b111, 3);
      reset = 1'b0;
      segment(3'b000, 4);

      segment(3'b010, 5);
      segment(3'b000, 6);
      segment(3'b001, 30);
      segment(3'b000, 6);
      segment(3'b110, 10);
      segment(3'b100, 15);
      segment(3'b000, 6);
      segment(3'b001, 8);
      segment(3'b000, 6);
      segment(3'b001, 9);
      segment(3'b000, 6);

      segment(3'b100, 20);
      check("pre_reset_repeating", 32'(repeating), 32'(1));
      #2 reset = 1'b1;
      #1;
      check("async_rst_pulse", 32'(btn_pulse), 32'(0));
      check("async_rst_held", 32'(btn_held), 32'(0));
      check("async_rst_repeating", 32'(repeating), 32'(0));
      segment(3'b000, 2);
      reset = 1'b0;
      segment(3'b000, 8);

      for (int seg = 0; seg < 80; seg++) begin
         logic [NB-1:0] mask;
         int            len;
         mask = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom_range(1, 7));
         len  = $urandom_range(1, 40);
         segment(mask, len);
      end
      segment(3'b000, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
